// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM arbiter: bus widths, arbiter FSM encoding, port ids.
package ram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM between ports A and B, with a bounded bus lock.
// Grant is same-cycle combinational, read data one cycle later; a losing requester just holds its req.
module ram_arbiter #(
  parameter int   ADDR_W     = ram_pkg::ADDR_W,
  parameter int   DATA_W     = ram_pkg::DATA_W,
  parameter int   LOCK_MAX   = 16,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,

  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata
);

  import ram_pkg::*;

  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] lock_cnt, cnt_nxt;
  logic             a_rv_q, b_rv_q;

  // Grant selection and next-state; nothing is granted while reset is held.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = lock_cnt;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;

    if (!rst) begin
      unique case (state)
        ARB: begin
          if (a_req && (!b_req || last == PORT_B)) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end
          if (a_gnt && a_lock) begin
            state_nxt = LOCK_A;
            cnt_nxt   = CNT_ONE;
          end
          if (b_gnt && b_lock) begin
            state_nxt = LOCK_B;
            cnt_nxt   = CNT_ONE;
          end
        end

        LOCK_A: begin
          if (!a_req) begin
            state_nxt = ARB;
            cnt_nxt   = '0;
          end else if (lock_cnt == CNT_MAX && b_req) begin
            // Lock expired with B waiting: B takes this cycle, A's lock is ignored.
            b_gnt     = 1'b1;
            state_nxt = ARB;
            cnt_nxt   = '0;
          end else begin
            a_gnt = 1'b1;
            if (!a_lock) begin
              state_nxt = ARB;
              cnt_nxt   = '0;
            end else if (lock_cnt != CNT_MAX) begin
              cnt_nxt = lock_cnt + CNT_ONE;
            end
          end
        end

        LOCK_B: begin
          if (!b_req) begin
            state_nxt = ARB;
            cnt_nxt   = '0;
          end else if (lock_cnt == CNT_MAX && a_req) begin
            a_gnt     = 1'b1;
            state_nxt = ARB;
            cnt_nxt   = '0;
          end else begin
            b_gnt = 1'b1;
            if (!b_lock) begin
              state_nxt = ARB;
              cnt_nxt   = '0;
            end else if (lock_cnt != CNT_MAX) begin
              cnt_nxt = lock_cnt + CNT_ONE;
            end
          end
        end

        default: begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end
      endcase

      if (a_gnt) last_nxt = PORT_A;
      if (b_gnt) last_nxt = PORT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      last     <= RESET_LAST;
      lock_cnt <= '0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= cnt_nxt;
      a_rv_q   <= a_gnt & ~a_we;
      b_rv_q   <= b_gnt & ~b_we;
    end
  end

  // RAM side follows A when idle; write strobe only ever accompanies a grant.
  assign ram_addr  = b_gnt ? b_addr  : a_addr;
  assign ram_wdata = b_gnt ? b_wdata : a_wdata;
  assign ram_write = (a_gnt & a_we) | (b_gnt & b_we);

  // A read granted just before reset rises must not surface during reset.
  assign a_rvalid = a_rv_q & ~rst;
  assign b_rvalid = b_rv_q & ~rst;
  assign rdata    = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 256x8 sync RAM and a reference arbiter model.
module tb_ram_arbiter;
  import ram_pkg::*;

  localparam int   LOCK_MAX   = 16;
  localparam logic RESET_LAST = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
  logic       b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_write;
  logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int passed = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] m_mem [256];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  arb_state_t m_state, m_ns;
  logic       m_last, m_nl, m_ea, m_eb, m_pend_a, m_pend_b, m_w;
  int         m_cnt, m_nc;
  logic [7:0] m_addr, m_wd, exp_d;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W(8), .DATA_W(8), .LOCK_MAX(LOCK_MAX), .RESET_LAST(RESET_LAST)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write), .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_val(input int addr);
    return 8'((addr * 7 + 3) & 255);
  endfunction

  // Behavioural RAM: registered read, one-cycle latency.
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ram_write) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Scoreboard monitor: reference arbiter, memory model and read-return queues.
  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    m_state = ARB; m_last = RESET_LAST; m_cnt = 0; m_pend_a = 1'b0; m_pend_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if ({a_gnt, b_gnt, ram_write, a_rvalid, b_rvalid} !== 5'b0)
          $display("FAIL mon_reset_quiet: got %b expected 00000", {a_gnt, b_gnt, ram_write, a_rvalid, b_rvalid});
        else passed++;
        m_state = ARB; m_last = RESET_LAST; m_cnt = 0; m_pend_a = 1'b0; m_pend_b = 1'b0;
        qa.delete(); qb.delete();
      end else begin
        checks++;
        if ({a_rvalid, b_rvalid} !== {m_pend_a, m_pend_b})
          $display("FAIL mon_rvalid: got %b expected %b", {a_rvalid, b_rvalid}, {m_pend_a, m_pend_b});
        else passed++;
        if (a_rvalid === 1'b1 && qa.size() > 0) begin
          exp_d = qa.pop_front();
          checks++;
          if (rdata !== exp_d) $display("FAIL mon_rdata_a: got %h expected %h", rdata, exp_d);
          else passed++;
        end
        if (b_rvalid === 1'b1 && qb.size() > 0) begin
          exp_d = qb.pop_front();
          checks++;
          if (rdata !== exp_d) $display("FAIL mon_rdata_b: got %h expected %h", rdata, exp_d);
          else passed++;
        end

        m_ea = 1'b0; m_eb = 1'b0; m_ns = m_state; m_nl = m_last; m_nc = m_cnt;
        if (m_state == ARB) begin
          if (a_req && (!b_req || m_last)) m_ea = 1'b1;
          else if (b_req) m_eb = 1'b1;
          if (m_ea && a_lock) begin m_ns = LOCK_A; m_nc = 1; end
          if (m_eb && b_lock) begin m_ns = LOCK_B; m_nc = 1; end
        end else if (m_state == LOCK_A) begin
          if (!a_req) begin m_ns = ARB; m_nc = 0; end
          else if (m_cnt == LOCK_MAX && b_req) begin m_eb = 1'b1; m_ns = ARB; m_nc = 0; end
          else begin
            m_ea = 1'b1;
            if (!a_lock) begin m_ns = ARB; m_nc = 0; end
            else if (m_cnt < LOCK_MAX) m_nc = m_cnt + 1;
          end
        end else begin
          if (!b_req) begin m_ns = ARB; m_nc = 0; end
          else if (m_cnt == LOCK_MAX && a_req) begin m_ea = 1'b1; m_ns = ARB; m_nc = 0; end
          else begin
            m_eb = 1'b1;
            if (!b_lock) begin m_ns = ARB; m_nc = 0; end
            else if (m_cnt < LOCK_MAX) m_nc = m_cnt + 1;
          end
        end
        if (m_ea) m_nl = 1'b0;
        if (m_eb) m_nl = 1'b1;

        checks++;
        if ({a_gnt, b_gnt} !== {m_ea, m_eb})
          $display("FAIL mon_grant: got %b expected %b", {a_gnt, b_gnt}, {m_ea, m_eb});
        else passed++;

        m_w    = (m_ea && a_we) || (m_eb && b_we);
        m_addr = m_eb ? b_addr : a_addr;
        m_wd   = m_eb ? b_wdata : a_wdata;
        checks++;
        if (ram_write !== m_w || ram_addr !== m_addr || (m_w && ram_wdata !== m_wd))
          $display("FAIL mon_ram_bus: got w=%b a=%h d=%h expected w=%b a=%h d=%h",
                   ram_write, ram_addr, ram_wdata, m_w, m_addr, m_wd);
        else passed++;

        checks++;
        if (int'(dut.lock_cnt) > LOCK_MAX)
          $display("FAIL mon_lock_cnt_bound: got %0d expected <= %0d", dut.lock_cnt, LOCK_MAX);
        else passed++;

        if (m_ea && !a_we) qa.push_back(m_mem[a_addr]);
        if (m_eb && !b_we) qb.push_back(m_mem[b_addr]);
        if (m_w) m_mem[m_addr] = m_wd;
        m_pend_a = m_ea && !a_we;
        m_pend_b = m_eb && !b_we;
        m_state = m_ns; m_last = m_nl; m_cnt = m_nc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, we, lock, input logic [7:0] addr, wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, we, lock, input logic [7:0] addr, wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_a(0, 0, 0, 8'h00, 8'h00);
    drive_b(0, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1, 1, 0, 8'h33, 8'hEE);
    drive_b(1, 1, 1, 8'h34, 8'hEF);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {a_gnt, b_gnt}); else passed++;
    checks++;
    if (ram_write !== 1'b0) $display("FAIL reset_write: got %b expected 0", ram_write); else passed++;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {a_rvalid, b_rvalid}); else passed++;
    tick();
    rst = 1'b0;
    drive_a(1, 0, 0, 8'h41, 8'h00);
    drive_b(1, 0, 0, 8'h81, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL reset_first_tie: got %b expected 10", {a_gnt, b_gnt}); else passed++;
    tick();
    drive_a(0, 0, 0, 8'h00, 8'h00);
    drive_b(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid, rdata} !== {2'b10, init_val(8'h41)})
      $display("FAIL reset_first_read: got %b/%h expected 10/%h", {a_rvalid, b_rvalid}, rdata, init_val(8'h41));
    else passed++;
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    drive_a(1, 1, 0, 8'h10, 8'h5A);
    @(negedge clk);
    checks++;
    if ({a_gnt, ram_write} !== 2'b11) $display("FAIL wr_gnt: got %b expected 11", {a_gnt, ram_write}); else passed++;
    tick();
    drive_a(1, 0, 0, 8'h10, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, ram_write, a_rvalid} !== 3'b100) $display("FAIL rd_gnt: got %b expected 100", {a_gnt, ram_write, a_rvalid}); else passed++;
    tick();
    drive_a(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b10) $display("FAIL rd_rvalid: got %b expected 10", {a_rvalid, b_rvalid}); else passed++;
    checks++;
    if (rdata !== 8'h5A) $display("FAIL rd_data: got %h expected 5a", rdata); else passed++;
    tick();
  endtask

  task automatic test_alternate();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 0, 0, 8'(8'h40 + i / 2), 8'h00);
      drive_b(1, 0, 0, 8'(8'h80 + i / 2), 8'h00);
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_gnt_%0d: got %b expected %b", i, {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      else passed++;
      if (i > 0) begin
        exp = ((i - 1) % 2 == 0) ? init_val(8'h40 + (i - 1) / 2) : init_val(8'h80 + (i - 1) / 2);
        checks++;
        if ({a_rvalid, b_rvalid, rdata} !== {((i - 1) % 2 == 0) ? 2'b10 : 2'b01, exp})
          $display("FAIL alt_ret_%0d: got %b/%h expected data %h", i, {a_rvalid, b_rvalid}, rdata, exp);
        else passed++;
      end
      tick();
    end
    drive_a(0, 0, 0, 8'h00, 8'h00);
    drive_b(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid, rdata} !== {2'b01, init_val(8'h83)})
      $display("FAIL alt_last: got %b/%h expected 01/%h", {a_rvalid, b_rvalid}, rdata, init_val(8'h83));
    else passed++;
    tick();
  endtask

  task automatic test_lock_b();
    do_reset();
    drive_a(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) $display("FAIL lockb_pre: got %b expected 1", a_gnt); else passed++;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_b(1, 1, (k < 3), 8'(8'h20 + k), 8'(8'hC0 + k));
      drive_a(1, 0, 0, 8'h30, 8'h00);
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt} !== 2'b01) $display("FAIL lockb_burst_%0d: got %b expected 01", k, {a_gnt, b_gnt}); else passed++;
      tick();
    end
    drive_b(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) $display("FAIL lockb_a_after: got %b expected 1", a_gnt); else passed++;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_a(1, 0, 0, 8'(8'h20 + k), 8'h00);
      else       drive_a(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if ({a_rvalid, rdata} !== {1'b1, 8'(8'hC0 + k - 1)})
          $display("FAIL lockb_mem_%0d: got %b/%h expected 1/%h", k - 1, a_rvalid, rdata, 8'(8'hC0 + k - 1));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_lock_max();
    logic eb;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      drive_a(1, 0, 1, 8'h50, 8'h00);
      drive_b(1, 0, 0, 8'h90, 8'h00);
      eb = (c % (LOCK_MAX + 1) == 0);
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt} !== {~eb, eb})
        $display("FAIL lockmax_c%0d: got %b expected %b", c, {a_gnt, b_gnt}, {~eb, eb});
      else passed++;
      tick();
    end
    drive_a(0, 0, 0, 8'h00, 8'h00);
    drive_b(0, 0, 0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_lock();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_a(1, 0, 1, 8'(8'h60 + k), 8'h00);
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1) $display("FAIL rstlock_pre_%0d: got %b expected 1", k, a_gnt); else passed++;
      tick();
    end
    rst = 1'b1;
    drive_a(1, 0, 1, 8'h63, 8'h00);
    drive_b(1, 1, 0, 8'h61, 8'h99);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, ram_write} !== 4'b0000)
      $display("FAIL rstlock_quiet: got %b expected 0000", {a_gnt, b_gnt, a_rvalid, ram_write});
    else passed++;
    tick();
    rst = 1'b0;
    drive_a(1, 0, 0, 8'h64, 8'h00);
    drive_b(1, 0, 0, 8'h65, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, a_rvalid} !== 3'b100)
      $display("FAIL rstlock_tie: got %b expected 100", {a_gnt, b_gnt, a_rvalid});
    else passed++;
    tick();
    drive_a(0, 0, 0, 8'h00, 8'h00);
    drive_b(0, 0, 0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_random();
    logic ag, bg;
    int   lp;
    ag = 1'b0;
    bg = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      lp = ((c / 400) % 2 == 1) ? 9 : 2;
      if (!a_req || ag) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_addr = 8'($urandom_range(0, 31)); a_wdata = 8'($urandom);
      end
      if (!b_req || bg) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_addr = 8'($urandom_range(0, 31)); b_wdata = 8'($urandom);
      end
      a_lock = ($urandom_range(0, 9) < lp);
      b_lock = ($urandom_range(0, 9) < lp);
      @(negedge clk);
      ag = a_gnt;
      bg = b_gnt;
      checks++;
      if (a_gnt === 1'b1 && b_gnt === 1'b1) $display("FAIL rand_double_grant: got 11 at cycle %0d expected not 11", c);
      else passed++;
      tick();
    end
    drive_a(0, 0, 0, 8'h00, 8'h00);
    drive_b(0, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_write_read();
    test_alternate();
    test_lock_b();
    test_lock_max();
    test_reset_lock();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
